// File: rtl/rs232_rx_fifo.sv
//------------------------------------------------------------------------------
// Module   : rs232_rx_fifo
// Purpose  : Receive FIFO behind the RS232 receiver: acknowledges each byte once,
//            buffers it, and offers a first-word-fall-through read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rs232_rx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_rdy_i,
    input  logic [7:0]    rx_data_i,
    output logic          rx_done_o,
    input  logic          rd_i,
    output logic          rdy_o,
    output logic [7:0]    data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    input  logic          flush_i,
    output logic          ovf_o,
    input  logic          ovf_clr_i
);

    localparam int          DEPTH_INT = 1 << AW;
    localparam logic [AW:0] DEPTH     = {1'b1, {AW{1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [0:DEPTH_INT-1];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rx_done_q, rx_done_d;
    logic          ovf_q, ovf_d;

    logic          take, pop, accept, wr, drop;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        take   = (state_q == S_IDLE) && rx_rdy_i;
        pop    = rd_i && (count_q != '0);
        accept = (count_q != DEPTH) || pop;
        wr     = take && accept;
        drop   = take && !accept;
    end

    always_comb begin
        state_d   = state_q;
        rx_done_d = take;
        case (state_q)
            S_IDLE:  if (rx_rdy_i)  state_d = S_ACK;
            S_ACK:   if (!rx_rdy_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr)  wptr_d = wptr_q + 1'b1;
            if (pop) rptr_d = rptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
        end
    end

    // Set has priority over clear so no overflow event is ever lost.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)           ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rx_done_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rx_done_q <= rx_done_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr && !flush_i) mem_q[wptr_q] <= rx_data_i;
    end

    assign rx_done_o = rx_done_q;
    assign rdy_o     = (count_q != '0);
    assign data_o    = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
    assign count_o   = count_q;
    assign full_o    = (count_q == DEPTH);
    assign ovf_o     = ovf_q;

endmodule

`default_nettype wire
